// File: rtl/i2s_pkg.sv
// Shared constants and encodings for the I2S receive path.
package i2s_pkg;

  localparam int unsigned SAMPLE_WIDTH_DEF = 24;
  localparam int unsigned BCLK_DIV         = 32;
  localparam int unsigned LRCLK_DIV        = 1536;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  typedef enum logic {
    ST_SYNC = 1'b0,
    ST_RUN  = 1'b1
  } cap_state_e;

endpackage

// File: rtl/i2s_sample_fifo.sv
// Stereo frame FIFO built as a shift queue so the head is always entry 0 and
// comes straight from a register; keeps the sticky overflow flag for drops.
module i2s_sample_fifo #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  input  logic             ovf_clr_i,
  output logic [WIDTH-1:0] head_o,
  output logic             valid_o,
  output logic             overflow_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             pop, push_ok, drop;
  logic [CNT_W-1:0] wr_idx;

  always_comb begin
    pop     = pop_i && (count_q != '0);
    push_ok = push_i && ((count_q != CNT_W'(DEPTH)) || pop);
    drop    = push_i && !push_ok;
    wr_idx  = count_q - CNT_W'(pop);
    for (int i = 0; i < int'(DEPTH); i++) mem_d[i] = mem_q[i];
    if (pop) begin
      for (int i = 0; i < int'(DEPTH) - 1; i++) mem_d[i] = mem_q[i+1];
      mem_d[DEPTH-1] = '0;
    end
    if (push_ok) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (CNT_W'(i) == wr_idx) mem_d[i] = push_data_i;
      end
    end
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop);
    valid_d = (count_d != '0);
    // A drop in the same cycle as a clear keeps the flag set.
    ovf_d   = drop ? 1'b1 : (ovf_clr_i ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign head_o     = mem_q[0];
  assign valid_o    = valid_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/i2s_adc_capture.sv
// I2S ADC receiver: synchronises bclk/lrclk/adcdat, assembles left/right words
// into stereo frames and queues them on a valid/ready stream.
module i2s_adc_capture
  import i2s_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
  parameter int unsigned DATA_DELAY   = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i2s_bclk,
  input  logic                    i2s_lrclk,
  input  logic                    i2s_adcdat,
  output logic [SAMPLE_WIDTH-1:0] sample_left,
  output logic [SAMPLE_WIDTH-1:0] sample_right,
  output logic                    sample_valid,
  input  logic                    sample_ready,
  output logic                    overflow,
  input  logic                    overflow_clr
);

  localparam int unsigned IDX_W   = $clog2(SAMPLE_WIDTH + DATA_DELAY + 1);
  localparam int unsigned REL_W   = IDX_W + 1;
  localparam int unsigned FRAME_W = 2 * SAMPLE_WIDTH;
  localparam logic [REL_W-1:0] DD_X = REL_W'(DATA_DELAY);
  localparam logic [REL_W-1:0] SW_X = REL_W'(SAMPLE_WIDTH);
  localparam logic DLY_ZERO = (DATA_DELAY == 0);

  logic bclk_meta_q, bclk_sync_q, bclk_prev_q;
  logic lr_meta_q, lr_sync_q;
  logic dat_meta_q, dat_sync_q;

  cap_state_e             state_q, state_d;
  logic [SAMPLE_WIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    ch_q, ch_d;
  logic                    lr_prev_q, lr_prev_d;
  logic                    cmt_valid_q, cmt_valid_d;
  logic                    cmt_ch_q, cmt_ch_d;
  logic [SAMPLE_WIDTH-1:0] cmt_word_q, cmt_word_d;
  logic [SAMPLE_WIDTH-1:0] left_hold_q, left_hold_d;
  logic                    left_ok_q, left_ok_d;
  logic                    push_q, push_d;
  logic [FRAME_W-1:0]      push_data_q, push_data_d;

  logic                    rise, lr_edge, take_bit, full_a;
  logic [SAMPLE_WIDTH-1:0] shift_a;
  logic [IDX_W-1:0]        idx_a;
  logic [REL_W-1:0]        rel_q, rel_a, bits_a, pad_sh;
  logic [FRAME_W-1:0]      head;

  // Two-flop synchronisers plus the previous synced bclk for rise detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bclk_meta_q <= 1'b0;
      bclk_sync_q <= 1'b0;
      bclk_prev_q <= 1'b0;
      lr_meta_q   <= 1'b0;
      lr_sync_q   <= 1'b0;
      dat_meta_q  <= 1'b0;
      dat_sync_q  <= 1'b0;
    end else begin
      bclk_meta_q <= i2s_bclk;
      bclk_sync_q <= bclk_meta_q;
      bclk_prev_q <= bclk_sync_q;
      lr_meta_q   <= i2s_lrclk;
      lr_sync_q   <= lr_meta_q;
      dat_meta_q  <= i2s_adcdat;
      dat_sync_q  <= dat_meta_q;
    end
  end

  assign rise    = bclk_sync_q && !bclk_prev_q;
  assign lr_edge = rise && (lr_sync_q != lr_prev_q);

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    ch_d        = ch_q;
    lr_prev_d   = lr_prev_q;
    cmt_valid_d = 1'b0;
    cmt_ch_d    = cmt_ch_q;
    cmt_word_d  = cmt_word_q;
    left_hold_d = left_hold_q;
    left_ok_d   = left_ok_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;

    // In left-justified mode the edge rise carries the new MSB, so the old
    // word must not take it; otherwise it is the old word's trailing bit.
    rel_q    = {1'b0, idx_q} - DD_X;
    take_bit = rise && (state_q == ST_RUN) && (rel_q < SW_X) && (!lr_edge || !DLY_ZERO);
    shift_a  = take_bit ? {shift_q[SAMPLE_WIDTH-2:0], dat_sync_q} : shift_q;
    idx_a    = take_bit ? idx_q + IDX_W'(1) : idx_q;
    rel_a    = {1'b0, idx_a} - DD_X;
    bits_a   = rel_a[IDX_W] ? '0 : rel_a;
    full_a   = (bits_a == SW_X);
    pad_sh   = SW_X - bits_a;

    if (rise) begin
      lr_prev_d = lr_sync_q;
      if (state_q == ST_RUN) begin
        shift_d = shift_a;
        idx_d   = idx_a;
        if ((take_bit && full_a) || (lr_edge && !full_a)) begin
          cmt_valid_d = 1'b1;
          cmt_ch_d    = ch_q;
          cmt_word_d  = shift_a << pad_sh;
        end
      end
      if (lr_edge && (state_q == ST_RUN || lr_sync_q == CH_LEFT)) begin
        state_d = ST_RUN;
        ch_d    = lr_sync_q;
        idx_d   = IDX_W'(1);
        shift_d = DLY_ZERO ? SAMPLE_WIDTH'(dat_sync_q) : '0;
      end
    end

    // Pair a committed right word with the held left word.
    if (cmt_valid_q) begin
      if (cmt_ch_q == CH_LEFT) begin
        left_hold_d = cmt_word_q;
        left_ok_d   = 1'b1;
      end else if (left_ok_q) begin
        push_d      = 1'b1;
        push_data_d = {left_hold_q, cmt_word_q};
        left_ok_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_SYNC;
      shift_q     <= '0;
      idx_q       <= '0;
      ch_q        <= CH_LEFT;
      lr_prev_q   <= 1'b0;
      cmt_valid_q <= 1'b0;
      cmt_ch_q    <= CH_LEFT;
      cmt_word_q  <= '0;
      left_hold_q <= '0;
      left_ok_q   <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      ch_q        <= ch_d;
      lr_prev_q   <= lr_prev_d;
      cmt_valid_q <= cmt_valid_d;
      cmt_ch_q    <= cmt_ch_d;
      cmt_word_q  <= cmt_word_d;
      left_hold_q <= left_hold_d;
      left_ok_q   <= left_ok_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
    end
  end

  i2s_sample_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_q),
    .push_data_i (push_data_q),
    .pop_i       (sample_ready),
    .ovf_clr_i   (overflow_clr),
    .head_o      (head),
    .valid_o     (sample_valid),
    .overflow_o  (overflow)
  );

  assign sample_left  = head[FRAME_W-1:SAMPLE_WIDTH];
  assign sample_right = head[SAMPLE_WIDTH-1:0];

endmodule

// File: tb/tb_i2s_adc_capture.sv
// Directed bench for i2s_adc_capture: a codec model plays bclk/lrclk/adcdat
// streams and frames seen at the stream output are checked against hand values.
module tb_i2s_adc_capture;

  logic        clk = 1'b0;
  logic        rst, rst2;
  logic        bclk, lrclk, adcdat;
  logic        sample_ready, overflow_clr, ready2, clr2;
  logic [23:0] sample_left, sample_right, left2, right2;
  logic        sample_valid, overflow, valid2, overflow2;

  always #5 clk = ~clk;

  i2s_adc_capture #(.SAMPLE_WIDTH(24), .DATA_DELAY(1), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .i2s_bclk(bclk), .i2s_lrclk(lrclk), .i2s_adcdat(adcdat),
    .sample_left(sample_left), .sample_right(sample_right), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .overflow(overflow), .overflow_clr(overflow_clr));

  i2s_adc_capture #(.SAMPLE_WIDTH(24), .DATA_DELAY(0), .FIFO_DEPTH(4)) dut_lj (
    .clk(clk), .rst(rst2), .i2s_bclk(bclk), .i2s_lrclk(lrclk), .i2s_adcdat(adcdat),
    .sample_left(left2), .sample_right(right2), .sample_valid(valid2),
    .sample_ready(ready2), .overflow(overflow2), .overflow_clr(clr2));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int mark_idx, mark_cyc, hook_idx, hook_sel;
  int rise_cyc, vhigh;
  logic v_prev = 1'b0;
  logic [23:0] cap_l[$];
  logic [23:0] cap_r[$];
  logic lr_arr [512];
  logic dat_arr [512];
  int n_st;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: first valid rise, valid-high cycles and accepted frames.
  always @(negedge clk) begin
    if (sample_valid && !v_prev && rise_cyc < 0) rise_cyc = cyc;
    if (sample_valid) vhigh = vhigh + 1;
    if (sample_valid && sample_ready) begin
      cap_l.push_back(sample_left);
      cap_r.push_back(sample_right);
    end
    v_prev = sample_valid;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic mon_clear();
    cap_l.delete();
    cap_r.delete();
    rise_cyc = -1;
    vhigh = 0;
  endtask

  task automatic clr_stream();
    for (int i = 0; i < 512; i++) begin
      lr_arr[i] = 1'b0;
      dat_arr[i] = 1'b0;
    end
    n_st = 0;
  endtask

  // One channel slot: lrclk level for slot_len bclks, word MSB first after dd bclks.
  task automatic add_slot(input logic lr, input logic [23:0] w, input int nbits,
                          input int slot_len, input int dd);
    for (int k = 0; k < slot_len; k++) lr_arr[n_st+k] = lr;
    for (int j = 0; j < nbits; j++) dat_arr[n_st+dd+j] = w[nbits-1-j];
    n_st += slot_len;
  endtask

  // Drive bclk = clk/32; lrclk/adcdat change with the bclk fall.
  task automatic play(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      bclk = 1'b0;
      lrclk = lr_arr[i];
      adcdat = dat_arr[i];
      repeat (16) begin @(posedge clk); #1; end
      bclk = 1'b1;
      if (i == mark_idx) mark_cyc = cyc;
      for (int k = 1; k <= 16; k++) begin
        @(posedge clk); #1;
        if (i == hook_idx && k == 4) begin
          if (hook_sel == 1) sample_ready = 1'b1;
          else overflow_clr = 1'b1;
        end
        if (i == hook_idx && k == 5) begin
          sample_ready = 1'b0;
          overflow_clr = 1'b0;
        end
      end
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic five_frames();
    clr_stream();
    add_slot(1'b1, 24'h0, 0, 24, 1);
    for (int n = 1; n <= 5; n++) begin
      add_slot(1'b0, 24'(n), 24, 24, 1);
      add_slot(1'b1, 24'(n + 'h100), 24, 24, 1);
    end
    add_slot(1'b0, 24'h0, 0, 24, 1);
  endtask

  function automatic logic [23:0] got_l(input int k);
    return (k < cap_l.size()) ? cap_l[k] : 24'h0;
  endfunction

  function automatic logic [23:0] got_r(input int k);
    return (k < cap_r.size()) ? cap_r[k] : 24'h0;
  endfunction

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    bclk = 1'b0; lrclk = 1'b0; adcdat = 1'b0;
    sample_ready = 1'b1; overflow_clr = 1'b0; ready2 = 1'b0; clr2 = 1'b0;
    mark_idx = -1; mark_cyc = 0; hook_idx = -1; hook_sel = 0;
    mon_clear();
    repeat (4) begin @(posedge clk); #1; end

    check("rst_valid", 32'(sample_valid), 32'h0);
    check("rst_left", 32'(sample_left), 32'h0);
    check("rst_right", 32'(sample_right), 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    check("rst_lj_valid", 32'(valid2), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Nominal I2S frame with latency measured from the right-LSB bclk rise.
    clr_stream();
    add_slot(1'b1, 24'h0, 0, 24, 1);
    add_slot(1'b0, 24'hA5A5A5, 24, 24, 1);
    add_slot(1'b1, 24'h123456, 24, 24, 1);
    add_slot(1'b0, 24'h0, 0, 24, 1);
    mon_clear();
    mark_idx = 72;
    play(0, n_st);
    mark_idx = -1;
    repeat (10) begin @(posedge clk); #1; end
    check("t1_latency", 32'(rise_cyc - mark_cyc), 32'd5);
    check("t1_valid_cycles", 32'(vhigh), 32'd1);
    check("t1_frames", 32'(cap_l.size()), 32'd1);
    check("t1_left", 32'(got_l(0)), 32'hA5A5A5);
    check("t1_right", 32'(got_r(0)), 32'h123456);

    // Reset released partway through a right slot.
    rst = 1'b1;
    clr_stream();
    add_slot(1'b0, 24'h555555, 24, 24, 1);
    add_slot(1'b1, 24'h0F0F0F, 24, 24, 1);
    add_slot(1'b0, 24'h000001, 24, 24, 1);
    add_slot(1'b1, 24'hFFFFFF, 24, 24, 1);
    add_slot(1'b0, 24'h800000, 24, 24, 1);
    add_slot(1'b1, 24'h7FFFFF, 24, 24, 1);
    add_slot(1'b0, 24'h0, 0, 24, 1);
    mon_clear();
    play(0, 34);
    rst = 1'b0;
    play(34, n_st);
    repeat (10) begin @(posedge clk); #1; end
    check("t2_frames", 32'(cap_l.size()), 32'd2);
    check("t2_left0", 32'(got_l(0)), 32'h000001);
    check("t2_right0", 32'(got_r(0)), 32'hFFFFFF);
    check("t2_left1", 32'(got_l(1)), 32'h800000);
    check("t2_right1", 32'(got_r(1)), 32'h7FFFFF);

    // Stalled consumer: frame 5 dropped, clear in the drop cycle loses.
    pulse_reset();
    sample_ready = 1'b0;
    five_frames();
    mon_clear();
    hook_idx = 264; hook_sel = 2;
    play(0, n_st);
    hook_idx = -1;
    repeat (10) begin @(posedge clk); #1; end
    check("t3_overflow", 32'(overflow), 32'h1);
    check("t3_valid", 32'(sample_valid), 32'h1);
    check("t3_head_left", 32'(sample_left), 32'h000001);
    check("t3_head_right", 32'(sample_right), 32'h000101);
    sample_ready = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    check("t3_frames", 32'(cap_l.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t3_left%0d", k), 32'(got_l(k)), 32'(k + 1));
      check($sformatf("t3_right%0d", k), 32'(got_r(k)), 32'(k + 'h101));
    end
    check("t3_drained", 32'(sample_valid), 32'h0);
    overflow_clr = 1'b1;
    @(posedge clk); #1;
    overflow_clr = 1'b0;
    @(posedge clk); #1;
    check("t3_overflow_cleared", 32'(overflow), 32'h0);

    // Full FIFO with ready pulsed exactly on the frame-5 push cycle.
    pulse_reset();
    sample_ready = 1'b0;
    five_frames();
    mon_clear();
    hook_idx = 264; hook_sel = 1;
    play(0, n_st);
    hook_idx = -1;
    repeat (10) begin @(posedge clk); #1; end
    check("t4_overflow", 32'(overflow), 32'h0);
    check("t4_popped", 32'(cap_l.size()), 32'd1);
    sample_ready = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    check("t4_frames", 32'(cap_l.size()), 32'd5);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t4_left%0d", k), 32'(got_l(k)), 32'(k + 1));
      check($sformatf("t4_right%0d", k), 32'(got_r(k)), 32'(k + 'h101));
    end

    // Left-justified instance with 20-bclk slots: short words are zero padded.
    rst2 = 1'b0;
    @(posedge clk); #1;
    clr_stream();
    add_slot(1'b1, 24'h0, 0, 20, 0);
    add_slot(1'b0, 24'h0ABCDE, 20, 20, 0);
    add_slot(1'b1, 24'h012345, 20, 20, 0);
    add_slot(1'b0, 24'h0, 0, 20, 0);
    play(0, n_st);
    repeat (10) begin @(posedge clk); #1; end
    check("t5_valid", 32'(valid2), 32'h1);
    check("t5_left", 32'(left2), 32'hABCDE0);
    check("t5_right", 32'(right2), 32'h123450);
    check("t5_overflow", 32'(overflow2), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_adc_capture.md
Name: i2s_adc_capture

Overview:
- Receive-side I2S stage, sitting downstream of the codec ADC output and alongside the top-level DAC path.
- Samples i2s_adcdat using the bclk/lrclk pair the top level already generates: 24-bit stereo, bclk = clk/32, lrclk = clk/1536, 24 bclk per channel slot.
- Assembles left/right words into stereo frames and buffers them in a small FIFO.
- Presents the frames on a valid/ready stream for a consumer such as a BRAM writer or loopback to the DAC path.

Parameters:
SAMPLE_WIDTH, 24, bits per channel word, MSB first
DATA_DELAY, 1, bclk rises between an lrclk edge and the channel MSB (1 = I2S mode, 0 = left-justified)
FIFO_DEPTH, 4, stereo frames buffered; power of two, at least 2

Ports:
clk  in  1  system clock, 73.728 MHz
rst  in  1  asynchronous, active-high reset
i2s_bclk  in  1  bit clock, sampled on clk
i2s_lrclk  in  1  word select; 0 = left, 1 = right
i2s_adcdat  in  1  serial ADC data from codec, changes on bclk fall
sample_left  out  SAMPLE_WIDTH  FIFO head left word
sample_right  out  SAMPLE_WIDTH  FIFO head right word
sample_valid  out  1  FIFO head valid
sample_ready  in  1  consumer accepts head when valid && ready
overflow  out  1  sticky: a frame was dropped because the FIFO was full
overflow_clr  in  1  clears overflow; a drop in the same cycle wins

Behaviour:
- Reset (async assert, sync release):
  - all outputs 0; FIFO empty; state = SYNC; shift register 0; bit count 0.
- Input synchronisation:
  - bclk, lrclk and adcdat each pass through a 2-flop synchroniser.
  - A bclk "rise event" is the synced bclk going from 0 to 1 (1 clk pulse).
  - lrclk and adcdat are sampled only at rise events.
- Edge detection:
  - At a rise event, lr_edge = (sampled lrclk != lrclk sampled at the previous rise event).
  - The new channel is the newly sampled lrclk value.
- State machine:
  - SYNC: ignore data. An lr_edge to 0 (left start) begins a left word and moves to RUN. Right-start edges in SYNC are ignored.
  - RUN: words are assembled continuously.
- Word assembly, at each rise event in RUN:
  - (1) If the in-progress word has fewer than SAMPLE_WIDTH bits, shift adcdat in at the LSB end.
  - (2) If the word reaches SAMPLE_WIDTH bits, commit it to the left or right holding register by its channel.
  - (3) If lr_edge: an incomplete in-progress word is zero-padded at the LSBs and committed. Then a new word starts for the new channel, with this rise counting as index 0.
  - Bits at indices 0..DATA_DELAY-1 are skipped. The MSB is index DATA_DELAY.
  - Steps (1)–(3) act on the same rise. With DATA_DELAY=1 and a 24-bclk slot, the old word's LSB arrives on the edge rise; it completes the old word, and the rise is then skipped for the new word.
  - Extra bits beyond SAMPLE_WIDTH before the next edge are ignored.
- Frame formation:
  - A left commit sets left_ok.
  - A right commit with left_ok set pushes {left, right} into the FIFO and clears left_ok.
  - A right commit without left_ok is discarded.
- FIFO:
  - Push when not full, or when full and a pop occurs in the same cycle.
  - Otherwise the frame is dropped and overflow is set.
  - Pop on sample_valid && sample_ready.
  - The head is stable while valid && !ready.
- Latency: sample_valid rises 5 clk cycles after the i2s_bclk input transition that delivers the right LSB, FIFO initially empty:
  - 2 sync
  - 1 edge detect / shift
  - 1 commit
  - 1 FIFO write
- Reset mid-frame: the partial word and frame are lost; capture resumes at the next left-start edge.

Decomposition:
- Package i2s_pkg holds:
  - SAMPLE_WIDTH default
  - capture state encoding (SYNC, RUN)
  - channel constants (LEFT=0, RIGHT=1)
  - clock-ratio constants: BCLK_DIV=32, LRCLK_DIV=1536
- One sub-module: i2s_sample_fifo, a synchronous FIFO of width 2*SAMPLE_WIDTH and depth FIFO_DEPTH with full/empty flags and simultaneous push/pop when full.

Test Plan:
- Nominal timing, DATA_DELAY=1, codec model sends L=0xA5A5A5, R=0x123456, ready=1 → one output frame with sample_left=0xA5A5A5, sample_right=0x123456, valid high for exactly 1 clk, 5 clks after the right LSB bclk edge.
- Reset released during a right slot, then frames (0x000001, 0xFFFFFF) and (0x800000, 0x7FFFFF) → the first output is (0x000001, 0xFFFFFF); no partial frame is emitted.
- ready=0, FIFO_DEPTH=4, 5 frames L=n, R=n+0x100 for n=1..5 → 4 frames held, overflow=1; after ready=1 the outputs are n=1..4 in order, and frame 5 is absent.
- FIFO full, with ready pulsed exactly on the cycle frame 5 is pushed → no drop, overflow stays 0, and all 5 frames are delivered.
- DATA_DELAY=0 with a 20-bclk slot → words are zero-padded: L=0xABCDE sent as a 20-bit MSB-first word is output as 0xABCDE0.
- overflow_clr asserted in the same cycle as a drop → overflow remains 1; asserted in a later cycle with no drop → overflow=0.
